// File: rtl/ex_hazard_ctrl.sv
// Hazard and forwarding controller beside the Execute stage: tracks in-flight rd's,
// registers the EX forward selects, inserts load-use stalls and sequences redirect squashes.
module ex_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             id_valid_ip,
  input  logic [4:0]       id_rs1_addr_ip,
  input  logic [4:0]       id_rs2_addr_ip,
  input  logic             id_rs1_used_ip,
  input  logic             id_rs2_used_ip,
  input  logic [4:0]       id_rd_addr_ip,
  input  logic             id_reg_write_ip,
  input  logic             id_is_load_ip,
  input  logic             ex_flush_en_ip,
  input  logic             ex_next_pc_valid_ip,
  output logic [1:0]       fa_mux_op,
  output logic [1:0]       fb_mux_op,
  output logic             stall_op,
  output logic             id_ex_bubble_op,
  output logic             if_id_flush_op,
  output logic [CNT_W-1:0] stall_count_op,
  output logic [CNT_W-1:0] flush_count_op
);

  localparam logic [1:0] FWD_REGFILE      = 2'b00;
  localparam logic [1:0] WB_RESULT_SELECT = 2'b01;
  localparam logic [1:0] EX_RESULT_SELECT = 2'b10;
  localparam logic [2:0] FLUSH_RELOAD     = 3'(FLUSH_CYCLES - 1);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  // The WB slot retires without influencing any output here, so only EX and MEM are held.
  logic       ex_valid_q, ex_wr_q, ex_load_q;
  logic [4:0] ex_rd_q;
  logic       mem_valid_q, mem_wr_q;
  logic [4:0] mem_rd_q;

  logic [1:0]       fa_q, fa_d, fb_q, fb_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic redirect, squash, accept, load_use, stall, bubble, ex_take;
  logic ex_prod, mem_prod;

  assign ex_prod  = ex_valid_q && ex_wr_q && (ex_rd_q != 5'd0);
  assign mem_prod = mem_valid_q && mem_wr_q && (mem_rd_q != 5'd0);
  assign redirect = ex_flush_en_ip && ex_next_pc_valid_ip;

  assign load_use = id_valid_ip && ex_prod && ex_load_q &&
                    ((id_rs1_used_ip && (id_rs1_addr_ip == ex_rd_q)) ||
                     (id_rs2_used_ip && (id_rs2_addr_ip == ex_rd_q)));

  // Squash has priority: a stall during a redirect would hold a wrong-path fetch.
  assign stall   = load_use && !squash;
  assign bubble  = load_use || squash;
  assign ex_take = id_valid_ip && !bubble;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    squash  = 1'b0;
    accept  = 1'b0;
    case (state_q)
      RUN: begin
        if (redirect) begin
          squash = 1'b1;
          accept = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            cnt_d   = FLUSH_RELOAD;
          end
        end
      end
      FLUSH: begin
        squash = 1'b1;
        if (redirect) begin
          accept = 1'b1;
          cnt_d  = FLUSH_RELOAD;
        end else if (cnt_q <= 3'd1) begin
          state_d = RUN;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // EX producer is the youngest, so it is tested before MEM.
  always_comb begin
    fa_d = FWD_REGFILE;
    fb_d = FWD_REGFILE;
    if (ex_take) begin
      if (id_rs1_used_ip && ex_prod && (id_rs1_addr_ip == ex_rd_q))
        fa_d = EX_RESULT_SELECT;
      else if (id_rs1_used_ip && mem_prod && (id_rs1_addr_ip == mem_rd_q))
        fa_d = WB_RESULT_SELECT;
      if (id_rs2_used_ip && ex_prod && (id_rs2_addr_ip == ex_rd_q))
        fb_d = EX_RESULT_SELECT;
      else if (id_rs2_used_ip && mem_prod && (id_rs2_addr_ip == mem_rd_q))
        fb_d = WB_RESULT_SELECT;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      cnt_q       <= 3'd0;
      ex_valid_q  <= 1'b0;
      ex_wr_q     <= 1'b0;
      ex_load_q   <= 1'b0;
      ex_rd_q     <= 5'd0;
      mem_valid_q <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_rd_q    <= 5'd0;
      fa_q        <= FWD_REGFILE;
      fb_q        <= FWD_REGFILE;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ex_valid_q  <= ex_take;
      ex_wr_q     <= id_reg_write_ip;
      ex_load_q   <= id_is_load_ip;
      ex_rd_q     <= id_rd_addr_ip;
      mem_valid_q <= ex_valid_q;
      mem_wr_q    <= ex_wr_q;
      mem_rd_q    <= ex_rd_q;
      fa_q        <= fa_d;
      fb_q        <= fb_d;
      if (stall && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (accept && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign fa_mux_op       = fa_q;
  assign fb_mux_op       = fb_q;
  assign stall_op        = stall;
  assign id_ex_bubble_op = bubble;
  assign if_id_flush_op  = squash;
  assign stall_count_op  = stall_cnt_q;
  assign flush_count_op  = flush_cnt_q;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl: forwarding, load-use stall, redirect squash
// and asynchronous reset, with hand-computed expectations.
module tb_ex_hazard_ctrl;

  localparam logic [1:0] DEF = 2'b00;
  localparam logic [1:0] WB  = 2'b01;
  localparam logic [1:0] EX  = 2'b10;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        id_valid_ip, id_rs1_used_ip, id_rs2_used_ip;
  logic [4:0]  id_rs1_addr_ip, id_rs2_addr_ip, id_rd_addr_ip;
  logic        id_reg_write_ip, id_is_load_ip;
  logic        ex_flush_en_ip, ex_next_pc_valid_ip;
  logic [1:0]  fa_mux_op, fb_mux_op;
  logic        stall_op, id_ex_bubble_op, if_id_flush_op;
  logic [15:0] stall_count_op, flush_count_op;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  ex_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
    .clock               (clock),
    .reset               (reset),
    .id_valid_ip         (id_valid_ip),
    .id_rs1_addr_ip      (id_rs1_addr_ip),
    .id_rs2_addr_ip      (id_rs2_addr_ip),
    .id_rs1_used_ip      (id_rs1_used_ip),
    .id_rs2_used_ip      (id_rs2_used_ip),
    .id_rd_addr_ip       (id_rd_addr_ip),
    .id_reg_write_ip     (id_reg_write_ip),
    .id_is_load_ip       (id_is_load_ip),
    .ex_flush_en_ip      (ex_flush_en_ip),
    .ex_next_pc_valid_ip (ex_next_pc_valid_ip),
    .fa_mux_op           (fa_mux_op),
    .fb_mux_op           (fb_mux_op),
    .stall_op            (stall_op),
    .id_ex_bubble_op     (id_ex_bubble_op),
    .if_id_flush_op      (if_id_flush_op),
    .stall_count_op      (stall_count_op),
    .flush_count_op      (flush_count_op)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic issue(input string name, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic wr, input logic ld);
    id_valid_ip     = 1'b1;
    id_rs1_addr_ip  = rs1;
    id_rs1_used_ip  = u1;
    id_rs2_addr_ip  = rs2;
    id_rs2_used_ip  = u2;
    id_rd_addr_ip   = rd;
    id_reg_write_ip = wr;
    id_is_load_ip   = ld;
    $display("[%0t] decode %s", $time, name);
  endtask

  task automatic idle();
    id_valid_ip     = 1'b0;
    id_rs1_addr_ip  = 5'd0;
    id_rs1_used_ip  = 1'b0;
    id_rs2_addr_ip  = 5'd0;
    id_rs2_used_ip  = 1'b0;
    id_rd_addr_ip   = 5'd0;
    id_reg_write_ip = 1'b0;
    id_is_load_ip   = 1'b0;
  endtask

  task automatic redirect(input logic en, input logic vld);
    ex_flush_en_ip      = en;
    ex_next_pc_valid_ip = vld;
    $display("[%0t] redirect en=%0b valid=%0b", $time, en, vld);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    idle();
    ex_flush_en_ip      = 1'b0;
    ex_next_pc_valid_ip = 1'b0;
    cyc();
    cyc();
    check("rst_fa", fa_mux_op, DEF);
    check("rst_fb", fb_mux_op, DEF);
    check("rst_stall", stall_op, 0);
    check("rst_bubble", id_ex_bubble_op, 0);
    check("rst_flush", if_id_flush_op, 0);
    check("rst_stall_cnt", stall_count_op, 0);
    check("rst_flush_cnt", flush_count_op, 0);
    reset = 1'b0;
    cyc();

    // Forward from EX
    issue("add x5,x1,x2", 5'd1, 1, 5'd2, 1, 5'd5, 1, 0);
    settle();
    check("fwdex_add_stall", stall_op, 0);
    cyc();
    check("fwdex_add_fa", fa_mux_op, DEF);
    issue("sub x6,x5,x3", 5'd5, 1, 5'd3, 1, 5'd6, 1, 0);
    settle();
    check("fwdex_sub_stall", stall_op, 0);
    check("fwdex_sub_bubble", id_ex_bubble_op, 0);
    cyc();
    check("fwdex_sub_fa", fa_mux_op, EX);
    check("fwdex_sub_fb", fb_mux_op, DEF);
    idle();
    cyc();
    check("fwdex_idle_fa", fa_mux_op, DEF);
    cyc();

    // Forward from WB across a nop (rd=x0 is not a producer)
    issue("add x5,x1,x2", 5'd1, 1, 5'd2, 1, 5'd5, 1, 0);
    cyc();
    issue("nop", 5'd0, 1, 5'd0, 1, 5'd0, 1, 0);
    cyc();
    issue("or x7,x5,x5", 5'd5, 1, 5'd5, 1, 5'd7, 1, 0);
    cyc();
    check("fwdwb_or_fa", fa_mux_op, WB);
    check("fwdwb_or_fb", fb_mux_op, WB);
    idle();
    cyc();
    cyc();

    // EX beats MEM; x0 never forwarded
    issue("add x5,x1,x2", 5'd1, 1, 5'd2, 1, 5'd5, 1, 0);
    cyc();
    issue("add x5,x1,x2", 5'd1, 1, 5'd2, 1, 5'd5, 1, 0);
    cyc();
    issue("and x8,x5,x0", 5'd5, 1, 5'd0, 1, 5'd8, 1, 0);
    cyc();
    check("prio_and_fa", fa_mux_op, EX);
    check("prio_and_fb", fb_mux_op, DEF);
    idle();
    cyc();
    cyc();

    // Load-use: one stall cycle, then forward from WB
    issue("lw x4,0(x1)", 5'd1, 1, 5'd0, 0, 5'd4, 1, 1);
    cyc();
    issue("add x9,x4,x4", 5'd4, 1, 5'd4, 1, 5'd9, 1, 0);
    settle();
    check("lu_stall", stall_op, 1);
    check("lu_bubble", id_ex_bubble_op, 1);
    check("lu_flush", if_id_flush_op, 0);
    cyc();
    check("lu_stall_once", stall_op, 0);
    check("lu_bubble_once", id_ex_bubble_op, 0);
    check("lu_bubble_fa", fa_mux_op, DEF);
    cyc();
    check("lu_add_fa", fa_mux_op, WB);
    check("lu_add_fb", fb_mux_op, WB);
    check("lu_stall_cnt", stall_count_op, 1);
    idle();
    cyc();
    cyc();

    // Load to x0, and load feeding only an unused source
    issue("lw x0,0(x1)", 5'd1, 1, 5'd0, 0, 5'd0, 1, 1);
    cyc();
    issue("add x9,x0,x0", 5'd0, 1, 5'd0, 1, 5'd9, 1, 0);
    settle();
    check("lux0_stall", stall_op, 0);
    cyc();
    issue("lw x4,0(x1)", 5'd1, 1, 5'd0, 0, 5'd4, 1, 1);
    cyc();
    issue("addi x9,x3 (rs2=x4 unused)", 5'd3, 1, 5'd4, 0, 5'd9, 1, 0);
    settle();
    check("luunused_stall", stall_op, 0);
    idle();
    cyc();
    cyc();
    check("lu_stall_cnt_hold", stall_count_op, 1);

    // Redirect: squash for 2 cycles
    redirect(1, 1);
    settle();
    check("rd_flush_c0", if_id_flush_op, 1);
    check("rd_bubble_c0", id_ex_bubble_op, 1);
    check("rd_stall_c0", stall_op, 0);
    cyc();
    redirect(0, 0);
    settle();
    check("rd_flush_c1", if_id_flush_op, 1);
    cyc();
    check("rd_flush_c2", if_id_flush_op, 0);
    check("rd_flush_cnt", flush_count_op, 1);
    redirect(1, 0);
    settle();
    check("rd_novalid_flush", if_id_flush_op, 0);
    cyc();
    check("rd_novalid_cnt", flush_count_op, 1);
    redirect(0, 0);

    // Redirect together with a load-use hazard
    issue("lw x4,0(x1)", 5'd1, 1, 5'd0, 0, 5'd4, 1, 1);
    cyc();
    issue("add x9,x4,x4", 5'd4, 1, 5'd4, 1, 5'd9, 1, 0);
    redirect(1, 1);
    settle();
    check("rdlu_stall", stall_op, 0);
    check("rdlu_flush", if_id_flush_op, 1);
    check("rdlu_bubble", id_ex_bubble_op, 1);
    cyc();
    redirect(0, 0);
    settle();
    check("rdlu_stall_c1", stall_op, 0);
    check("rdlu_flush_c1", if_id_flush_op, 1);
    cyc();
    check("rdlu_flush_c2", if_id_flush_op, 0);
    check("rdlu_stall_cnt", stall_count_op, 1);
    check("rdlu_flush_cnt", flush_count_op, 2);
    idle();
    cyc();
    cyc();

    // Second redirect during FLUSH extends squash
    redirect(1, 1);
    settle();
    check("rd2_flush_c0", if_id_flush_op, 1);
    cyc();
    settle();
    check("rd2_flush_c1", if_id_flush_op, 1);
    cyc();
    redirect(0, 0);
    settle();
    check("rd2_flush_c2", if_id_flush_op, 1);
    cyc();
    check("rd2_flush_c3", if_id_flush_op, 0);
    check("rd2_flush_cnt", flush_count_op, 4);

    // Asynchronous reset while in FLUSH
    redirect(1, 1);
    cyc();
    redirect(0, 0);
    settle();
    check("rst_mid_flush_pre", if_id_flush_op, 1);
    check("rst_mid_cnt_pre", flush_count_op, 5);
    reset = 1'b1;
    settle();
    check("arst_flush", if_id_flush_op, 0);
    check("arst_bubble", id_ex_bubble_op, 0);
    check("arst_stall", stall_op, 0);
    check("arst_fa", fa_mux_op, DEF);
    check("arst_flush_cnt", flush_count_op, 0);
    check("arst_stall_cnt", stall_count_op, 0);
    cyc();
    reset = 1'b0;
    cyc();
    settle();
    check("post_rst_flush", if_id_flush_op, 0);
    check("post_rst_flush_cnt", flush_count_op, 0);
    check("post_rst_stall_cnt", stall_count_op, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ex_hazard_ctrl.md
# ex_hazard_ctrl

Hazard and forwarding controller for the 5-stage RISCV pipeline. It sits beside the Execute stage and tracks the destination registers of in-flight instructions in EX, MEM and WB. From these it produces the registered forward A/B mux codes that the Execute stage consumes, and it detects load-use hazards, inserting one stall cycle. It also sequences the multi-cycle squash of younger instructions after an Execute-stage redirect (JAL/branch flush).

## Interface
- FLUSH_CYCLES, 2: cycles the IF/ID and ID/EX squash stays asserted after a redirect, counting the redirect cycle (legal range 1..7).
- CNT_W, 16: width of the saturating performance counters.

- clock  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- id_valid_ip  in  1  Decode holds a valid instruction.
- id_rs1_addr_ip, id_rs2_addr_ip  in  5  Decode source registers.
- id_rs1_used_ip, id_rs2_used_ip  in  1  the source is actually read.
- id_rd_addr_ip  in  5  Decode destination register.
- id_reg_write_ip  in  1  Decode instruction writes rd.
- id_is_load_ip  in  1  Decode instruction is a load.
- ex_flush_en_ip  in  1  flush request from Execute.
- ex_next_pc_valid_ip  in  1  Execute redirect address is valid.
- fa_mux_op, fb_mux_op  out  forward_mux_code  operand selects for the instruction now in EX.
- stall_op  out  1  hold PC and the IF/ID register.
- id_ex_bubble_op  out  1  load a NOP into ID/EX.
- if_id_flush_op  out  1  clear the IF/ID register.
- stall_count_op, flush_count_op  out  CNT_W  saturating event counters.

## Operation
- The block keeps a scoreboard of three slots: EX {valid, rd, wr, load}, MEM {valid, rd, wr}, WB {valid, rd, wr}.
  - Every edge, WB takes MEM and MEM takes EX.
  - EX takes the Decode fields when id_valid_ip is high and no bubble is inserted. Otherwise EX.valid becomes 0.
- A producer is a slot with valid=1, wr=1 and rd≠0. Register x0 is never forwarded and never causes a stall.
- Forward selection is computed from the Decode sources and registered on the same edge that moves the instruction into EX, so it is aligned with the Execute stage. For each used source, in priority order:
  - It matches the EX-slot producer (that instruction moves to MEM on this edge): code EX_RESULT_SELECT.
  - Else it matches the MEM-slot producer: code WB_RESULT_SELECT.
  - Else: the register-file (default) code.
  - An unused source or a bubble gets the default code.
- Load-use hazard (combinational): the EX slot is a load producer and its rd equals a used Decode source, with id_valid_ip=1.
  - Response: stall_op=1 and id_ex_bubble_op=1 for exactly one cycle.
  - The dependent instruction then enters EX with the load in WB, so it selects WB_RESULT_SELECT.
- The flush FSM has two states, RUN and FLUSH, plus a 3-bit counter cnt.
  - RUN, on ex_flush_en_ip & ex_next_pc_valid_ip: if_id_flush_op=1 and id_ex_bubble_op=1 in that same cycle.
    - If FLUSH_CYCLES>1, go to FLUSH with cnt=FLUSH_CYCLES-1.
  - FLUSH: if_id_flush_op=1 and id_ex_bubble_op=1. Decrement cnt; return to RUN when cnt reaches 1 and decrements.
  - A new redirect while in FLUSH reloads cnt.
- Flush overrides stall: stall_op=0 in any cycle where squash is asserted.
- ex_flush_en_ip without ex_next_pc_valid_ip is ignored.
- Counters:
  - stall_count_op increments each stall cycle.
  - flush_count_op increments once per accepted redirect.
  - Both saturate at all-ones.

## Timing
- Reset values: state RUN, cnt 0, all slots invalid, fa/fb at the default code, stall_op/id_ex_bubble_op/if_id_flush_op 0, counters 0.
- Reset mid-flush or mid-stall aborts immediately. No squash is asserted after reset deasserts.
- fa/fb: one-edge latency from the Decode fields; valid throughout the EX cycle.
- stall_op, id_ex_bubble_op, if_id_flush_op: combinational, same cycle as the cause.
- A stall cycle repeats at most once per load: after the bubble, the EX slot is invalid, so the hazard cannot persist.
- Simultaneous load-use and redirect: only the squash is asserted, and stall_count_op does not increment.
- Matches in both the EX and MEM slots: EX_RESULT_SELECT wins (youngest producer).

## Test plan
- Forward from EX: `add x5,x1,x2` then `sub x6,x5,x3`.
  - Required: sub in EX shows fa=EX_RESULT_SELECT and fb=default; no stall.
- Forward from WB and priority:
  - `add x5`, `nop`, `or x7,x5,x5`: fa=fb=WB_RESULT_SELECT.
  - `add x5`, `add x5`, `and x8,x5,x0`: fa=EX_RESULT_SELECT and fb=default. x0 is never forwarded.
- Load-use: `lw x4,0(x1)` then `add x9,x4,x4`.
  - Required: stall_op=1 and id_ex_bubble_op=1 for exactly 1 cycle; then add in EX with fa=fb=WB_RESULT_SELECT; stall_count_op=1.
- Load to x0 or unused source: `lw x0` followed by a read of x0 → no stall.
- Redirect with FLUSH_CYCLES=2: pulse flush_en+valid.
  - Required: squash high for exactly 2 cycles; flush_count_op=1.
  - Redirect together with a load-use hazard: stall_op=0.
  - Second redirect during FLUSH: squash extends for 2 cycles from that redirect.
- Reset asserted in the FLUSH state: all outputs return to reset values asynchronously; after release, no squash and counters at 0.
